apb_arb_master: RTL and testbench

- APB master that shares one APB slave (the 8-entry memory slave) between two local requesters.
- Round-robin arbitration picks the next requester.
- Sequences the APB SETUP/ACCESS phases and waits on PREADY.
- Returns read data with a done/error pulse to the owning requester.
- Sits between the local requesters and the slave's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY pins.

---
 rtl/apb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 16 +
 rtl/apb_arb_master.sv | 161 ++++++++++++++++
 tb/tb_apb_arb_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM encoding and default widths for the APB arbitrating master
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // last_i names the requester served most recently; on contention the other one wins
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - APB master sharing one slave between two requesters
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESET,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_wr0,
    input  logic                  i_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_done0,
    output logic                  o_done1,
    output logic                  o_err0,
    output logic                  o_err1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_PSEL,
    output logic                  o_PENABLE,
    output logic                  o_PWRITE,
    output logic [ADDR_WIDTH-1:0] o_PADDR,
    output logic [DATA_WIDTH-1:0] o_PWDATA,
    input  logic [DATA_WIDTH-1:0] i_PRDATA,
    input  logic                  i_PREADY
);

    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    apb_state_e            state_q, state_d;
    logic                  last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            arb_gnt;

    rr_arb2 u_arb (
        .req_i  ({i_req1, i_req0}),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        err_d     = err_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    gnt_d    = arb_gnt;
                    psel_d   = 1'b1;
                    pwrite_d = arb_gnt[1] ? i_wr1    : i_wr0;
                    paddr_d  = arb_gnt[1] ? i_addr1  : i_addr0;
                    pwdata_d = arb_gnt[1] ? i_wdata1 : i_wdata0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (i_PREADY) begin
                    if (!pwrite_q) begin
                        rdata_d = i_PRDATA;
                    end
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = gnt_q;
                    last_d    = gnt_q[1];
                    state_d   = DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    // abort leaves last_q alone so fairness tracks completed transfers only
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = gnt_q;
                    err_d     = gnt_q;
                    state_d   = DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                done_d  = 2'b00;
                err_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign o_gnt0    = gnt_q[0];
    assign o_gnt1    = gnt_q[1];
    assign o_done0   = done_q[0];
    assign o_done1   = done_q[1];
    assign o_err0    = err_q[0];
    assign o_err1    = err_q[1];
    assign o_rdata   = rdata_q;
    assign o_PSEL    = psel_q;
    assign o_PENABLE = penable_q;
    assign o_PWRITE  = pwrite_q;
    assign o_PADDR   = paddr_q;
    assign o_PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - self-checking bench for apb_arb_master with memory slave stub
module tb_apb_arb_master;

    localparam int TO = 4;

    logic       clk, rst;
    logic       req0, req1, wr0, wr1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0] rdata;
    logic       psel, pen, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready;

    int checks = 0;
    int errors = 0;
    int force_wait = 0;

    logic [7:0] smem [8];
    logic [7:0] mmem [8];

    apb_arb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(TO)) dut (
        .i_PCLK    (clk),
        .i_PRESET  (rst),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_wr0     (wr0),
        .i_wr1     (wr1),
        .i_addr0   (addr0),
        .i_addr1   (addr1),
        .i_wdata0  (wdata0),
        .i_wdata1  (wdata1),
        .o_gnt0    (gnt0),
        .o_gnt1    (gnt1),
        .o_done0   (done0),
        .o_done1   (done1),
        .o_err0    (err0),
        .o_err1    (err1),
        .o_rdata   (rdata),
        .o_PSEL    (psel),
        .o_PENABLE (pen),
        .o_PWRITE  (pwrite),
        .o_PADDR   (paddr),
        .o_PWDATA  (pwdata),
        .i_PRDATA  (prdata),
        .i_PREADY  (pready)
    );

    assign prdata = smem[paddr[2:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int r, input string nm);
        int n;
        n = 0;
        while (((r == 0) ? done0 : done1) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(nm, (r == 0) ? done0 : done1, 1);
    endtask

    // Slave stub: memory plus a per-transfer number of PREADY-low ACCESS cycles
    initial begin
        int waits;
        int r;
        waits  = 0;
        pready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (psel && !pen) begin
                if (force_wait >= 0) begin
                    waits = force_wait;
                end else begin
                    r = int'($urandom_range(0, 9));
                    waits = (r < 5) ? 0 : (r < 8) ? r - 4 : 6;
                end
                pready = 1'b0;
            end else if (psel && pen) begin
                pready = (waits == 0);
                if (waits > 0) waits--;
            end else begin
                pready = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) smem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && psel && pen && pready && pwrite) smem[paddr[2:0]] = pwdata;
        end
    end

    // Transaction-timeline reference model, compared on every falling edge
    logic [1:0] e_gnt, e_done, e_err;
    logic       e_psel, e_pen, e_pwrite;
    logic [7:0] e_paddr, e_pwdata, e_rdata;
    bit         m_busy, m_last, m_end;
    int         m_t, m_acc, m_owner;

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_end = 0; m_t = 0; m_acc = 0; m_owner = 0;
        e_gnt = 0; e_done = 0; e_err = 0;
        e_psel = 0; e_pen = 0; e_pwrite = 0;
        e_paddr = 0; e_pwdata = 0; e_rdata = 0;
    endtask

    initial begin
        bit fin;
        for (int i = 0; i < 8; i++) mmem[i] = 8'h00;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("ctl", {gnt1, gnt0, done1, done0, err1, err0, psel, pen, pwrite},
                       {e_gnt, e_done, e_err, e_psel, e_pen, e_pwrite});
            chk("bus", {paddr, pwdata}, {e_paddr, e_pwdata});
            chk("rdata", rdata, e_rdata);
            chk("penable_without_psel", pen & ~psel, 0);
            chk("multi_owner", ($countones({gnt1, gnt0}) > 1) || ($countones({done1, done0}) > 1)
                               || ($countones({err1, err0}) > 1), 0);
            if (!rst) begin
                if (!m_busy) begin
                    if (req0 || req1) begin
                        m_owner = (req0 && req1) ? int'(!m_last) : int'(req1);
                        m_busy = 1; m_t = 1; m_acc = 0; m_end = 0;
                        e_pwrite = (m_owner == 1) ? wr1 : wr0;
                        e_paddr  = (m_owner == 1) ? addr1 : addr0;
                        e_pwdata = (m_owner == 1) ? wdata1 : wdata0;
                        e_psel = 1;
                        e_gnt[m_owner] = 1'b1;
                    end
                end else if (m_t == 1) begin
                    e_pen = 1;
                    m_t = 2;
                end else if (!m_end) begin
                    m_acc++;
                    fin = 0;
                    if (pready) begin
                        if (e_pwrite) mmem[e_paddr[2:0]] = e_pwdata;
                        else e_rdata = mmem[e_paddr[2:0]];
                        m_last = (m_owner == 1);
                        fin = 1;
                    end else if (TO != 0 && m_acc == TO) begin
                        e_err[m_owner] = 1'b1;
                        fin = 1;
                    end
                    if (fin) begin
                        e_psel = 0; e_pen = 0;
                        e_done[m_owner] = 1'b1;
                        m_end = 1;
                    end
                end else begin
                    e_gnt = 0; e_done = 0; e_err = 0;
                    m_busy = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic d0, d1;
        rst = 0; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", {gnt1, gnt0, done1, done0, err1, err0, psel, pen, pwrite, paddr, pwdata, rdata}, 0);

        // write 0xA5 to address 3
        req0 = 1; wr0 = 1; addr0 = 8'd3; wdata0 = 8'hA5;
        tick(); chk("t1_setup", {psel, pen, gnt0}, 3'b101);
        tick(); chk("t1_access", {psel, pen}, 2'b11);
        tick(); chk("t1_done", {done0, err0, psel, pen}, 4'b1000);
        req0 = 0;
        tick(); chk("t1_slave_mem", smem[3], 8'hA5);

        // read it back
        req0 = 1; wr0 = 0; addr0 = 8'd3;
        tick(); chk("t2_setup_pwrite", {psel, pwrite}, 2'b10);
        tick(); chk("t2_access_pwrite", {pen, pwrite}, 2'b10);
        tick(); chk("t2_done_rdata", {done0, rdata}, {1'b1, 8'hA5});
        req0 = 0;
        tick();

        // timeout on a stuck slave; rdata must keep 0xA5
        force_wait = 1000;
        req0 = 1; wr0 = 0; addr0 = 8'd6;
        repeat (5) tick();
        chk("t5_no_early_done", done0, 0);
        tick(); chk("t5_timeout", {done0, err0, psel, pen}, 4'b1100);
        chk("t5_rdata_kept", rdata, 8'hA5);
        req0 = 0; force_wait = 0;
        tick();

        // simultaneous requests from reset: requester 0 first, requester 1 four cycles later
        do_reset();
        req0 = 1; wr0 = 1; addr0 = 8'd1; wdata0 = 8'h11;
        req1 = 1; wr1 = 1; addr1 = 8'd2; wdata1 = 8'h22;
        tick(); chk("t3_first_gnt", {gnt1, gnt0}, 2'b01);
        tick();
        tick(); chk("t3_done0", {done1, done0}, 2'b01);
        req0 = 0;
        tick();
        tick(); chk("t3_second_gnt", {gnt1, gnt0}, 2'b10);
        tick();
        tick(); chk("t3_done1", {done1, done0}, 2'b10);
        req1 = 0;
        tick();
        chk("t3_mem", {smem[1], smem[2]}, 16'h1122);

        // two PREADY-low cycles stretch the write to five cycles
        force_wait = 2;
        req0 = 1; wr0 = 1; addr0 = 8'd5; wdata0 = 8'h3C;
        repeat (4) tick();
        chk("t4_still_waiting", {done0, psel, pen}, 3'b011);
        tick(); chk("t4_done", {done0, err0}, 2'b10);
        req0 = 0; force_wait = 0;
        tick();
        chk("t4_mem", smem[5], 8'h3C);

        // async reset mid-ACCESS; requester 0 served last, so only reset makes it win again
        force_wait = 1000;
        req0 = 1; wr0 = 1; addr0 = 8'd7; wdata0 = 8'h77;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1 chk("t6_async_clear", {gnt1, gnt0, done1, done0, err1, err0, psel, pen, pwrite, paddr, pwdata, rdata}, 0);
        req1 = 1; wr1 = 0; addr1 = 8'd1;
        force_wait = 0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick(); chk("t6_rr_after_reset", {gnt1, gnt0}, 2'b01);
        wait_done(0, "t6_done0");
        req0 = 0;
        wait_done(1, "t6_done1");
        req1 = 0;
        tick();

        // randomized traffic with random wait states and occasional timeouts
        force_wait = -1;
        repeat (3000) begin
            @(negedge clk);
            d0 = done0;
            d1 = done1;
            tick();
            if (d0) req0 = 0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1; wr0 = 1'($urandom); addr0 = 8'($urandom); wdata0 = 8'($urandom);
            end
            if (d1) req1 = 0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1; wr1 = 1'($urandom); addr1 = 8'($urandom); wdata1 = 8'($urandom);
            end
        end
        req0 = 0; req1 = 0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
